// File: rtl/lc3b_mem_pkg.sv
// Shared definitions for the LC-3b memory unit.
//   state_t   : access FSM states
//   RW_WRITE  : value of rw that requests a write
//   SIZE_BYTE : value of datasize that requests a byte access
//   sext_byte : sign-extends a byte to the 16-bit datapath width
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b1;

  function automatic logic [15:0] sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// DEPTH x 8 byte storage with no reset (contents survive rst).
//   clk    : write clock
//   we     : byte write enables; we[0] writes addr, we[1] writes addr+1
//   addr   : byte address (addr+1 wraps modulo DEPTH)
//   wdata  : {byte for addr+1, byte for addr}
//   rdata0 : combinational read of addr
//   rdata1 : combinational read of addr+1
module lc3b_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [7:0]    rdata0,
  output logic [7:0]    rdata1
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] addr_p1;

  // Natural AW-bit overflow gives the modulo-DEPTH wrap.
  assign addr_p1 = addr + AW'(1);

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr]    <= wdata[7:0];
    if (we[1]) mem[addr_p1] <= wdata[15:8];
  end

  assign rdata0 = mem[addr];
  assign rdata1 = mem[addr_p1];

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory unit: MAR/MDR front end, latency counter and R handshake
// over a little-endian byte array.
//   clk_50   : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   bus      : datapath bus value
//   ld_mar   : load MAR from bus (IDLE only)
//   ld_mdr   : load MDR from bus (IDLE only)
//   gate_mdr : drive MDR onto mdr_out
//   mio_en   : memory request, held high until r is seen
//   rw       : 1 = write, 0 = read (captured at acceptance)
//   datasize : 1 = byte, 0 = word (captured at acceptance)
//   mdr_out  : MDR when gate_mdr, else 0
//   r        : access complete
//   addr_err : unaligned word access, valid while r = 1
// Handshake: the requester raises mio_en and holds it until r = 1; r then
// stays high until the edge after mio_en returns low. The request is accepted
// on the first edge mio_en is high in IDLE.
module lc3b_mem_unit
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 5,
  parameter int WR_LAT = 10
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              gate_mdr,
  input  logic              mio_en,
  input  logic              rw,
  input  logic              datasize,
  output logic [DATA_W-1:0] mdr_out,
  output logic              r,
  output logic              addr_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [CNT_W-1:0]  cnt;
  logic              size_q;
  logic              r_q;
  logic              err_q;

  logic [AW-1:0]     a;
  logic [7:0]        rd0;
  logic [7:0]        rd1;
  logic              unaligned;
  logic              finishing;
  logic [1:0]        we;

  assign a         = mar[AW-1:0];
  assign unaligned = (size_q != SIZE_BYTE) && mar[0];
  assign finishing = ((state == READ) || (state == WRITE)) && (cnt == '0);

  // The commit is tied to the single busy->DONE edge, so a long hold in DONE
  // cannot write again, and an async reset (state forced to IDLE) kills it.
  always_comb begin
    we = 2'b00;
    if (finishing && (state == WRITE) && !unaligned) begin
      we[0] = 1'b1;
      we[1] = (size_q != SIZE_BYTE);
    end
  end

  lc3b_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk_50),
    .we     (we),
    .addr   (a),
    .wdata  (mdr[15:0]),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mar    <= '0;
      mdr    <= '0;
      cnt    <= '0;
      size_q <= 1'b0;
      r_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_mar) mar <= ADDR_W'(bus);
          if (ld_mdr) mdr <= bus;
          // Accepted this edge; the busy states see the freshly loaded MAR/MDR.
          if (mio_en) begin
            size_q <= datasize;
            if (rw == RW_WRITE) begin
              state <= WRITE;
              cnt   <= CNT_W'(WR_LAT - 1);
            end else begin
              state <= READ;
              cnt   <= CNT_W'(RD_LAT - 1);
            end
          end
        end
        READ, WRITE: begin
          if (cnt == '0) begin
            state <= DONE;
            r_q   <= 1'b1;
            err_q <= unaligned;
            if ((state == READ) && !unaligned) begin
              if (size_q == SIZE_BYTE) mdr <= sext_byte(rd0);
              else                     mdr <= {rd1, rd0};
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (!mio_en) begin
            state <= IDLE;
            r_q   <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r        = r_q;
  assign addr_err = err_q;
  assign mdr_out  = gate_mdr ? mdr : '0;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
module tb_lc3b_mem_unit;

  logic        clk_50;
  logic        rst;
  logic [15:0] bus;
  logic        ld_mar;
  logic        ld_mdr;
  logic        gate_mdr;
  logic        mio_en;
  logic        rw;
  logic        datasize;
  logic [15:0] mdr_out;
  logic        r;
  logic        addr_err;

  int n_vec;
  int n_err;

  lc3b_mem_unit #(
    .ADDR_W (16),
    .DATA_W (16),
    .DEPTH  (256),
    .RD_LAT (5),
    .WR_LAT (10)
  ) dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .bus      (bus),
    .ld_mar   (ld_mar),
    .ld_mdr   (ld_mdr),
    .gate_mdr (gate_mdr),
    .mio_en   (mio_en),
    .rw       (rw),
    .datasize (datasize),
    .mdr_out  (mdr_out),
    .r        (r),
    .addr_err (addr_err)
  );

  // ---------------- clock ----------------
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One complete access. same_cycle raises ld_mar together with mio_en.
  // hold > 0 keeps mio_en high that many cycles past r while hammering
  // ld_mar/ld_mdr/rw/datasize, which must all be ignored.
  task automatic access(input string tag, input logic wr, input logic byte_sz,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input bit load_mdr, input bit same_cycle, input int hold,
                        output int lat, output logic err, output logic [15:0] rdata);
    int r_lost;
    @(negedge clk_50);
    if (load_mdr) begin
      bus = wdata; ld_mdr = 1'b1;
      @(negedge clk_50);
      ld_mdr = 1'b0;
    end
    bus = addr; ld_mar = 1'b1;
    if (!same_cycle) begin
      @(negedge clk_50);
      ld_mar = 1'b0;
    end
    mio_en = 1'b1; rw = wr; datasize = byte_sz;
    @(posedge clk_50);  // acceptance edge
    #1;
    ld_mar = 1'b0;
    bus = 16'h5555;
    if (hold > 0) begin
      ld_mar = 1'b1; ld_mdr = 1'b1; bus = 16'hDEAD; rw = ~wr; datasize = ~byte_sz;
    end
    lat = 0;
    while (!r && lat < 100) begin
      @(posedge clk_50);
      lat++;
      #1;
    end
    err = addr_err;
    r_lost = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_50);
      #1;
      if (!r) r_lost++;
    end
    if (hold > 0) chk({tag, "_hold_r"}, r_lost, 0);
    gate_mdr = 1'b1;
    #1 rdata = mdr_out;
    gate_mdr = 1'b0;
    @(negedge clk_50);
    mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    @(posedge clk_50);
    #1;
    chk({tag, "_r_drop"}, r, 1'b0);
    chk({tag, "_err_drop"}, addr_err, 1'b0);
  endtask

  task automatic do_write(input string tag, input logic byte_sz, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic exp_err);
    int lat; logic err; logic [15:0] rd;
    access(tag, 1'b1, byte_sz, addr, wdata, 1'b1, 1'b0, 0, lat, err, rd);
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_err"}, err, exp_err);
  endtask

  task automatic do_read(input string tag, input logic byte_sz, input logic [15:0] addr,
                         input logic [15:0] exp_data, input logic exp_err);
    int lat; logic err; logic [15:0] rd;
    access(tag, 1'b0, byte_sz, addr, 16'h0, 1'b0, 1'b0, 0, lat, err, rd);
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_data"}, rd, exp_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat; logic err; logic [15:0] rd;
    n_vec = 0; n_err = 0;
    rst = 1'b1; bus = '0; ld_mar = 0; ld_mdr = 0; gate_mdr = 0;
    mio_en = 0; rw = 0; datasize = 0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    rst = 1'b0;

    // reset state
    chk("rst_r", r, 1'b0);
    chk("rst_err", addr_err, 1'b0);
    gate_mdr = 1'b1; #1;
    chk("rst_mdr", mdr_out, 16'h0000);
    gate_mdr = 1'b0;

    // word write / read
    do_write("ww10", 1'b0, 16'h0010, 16'h1234, 1'b0);
    do_read("wr10", 1'b0, 16'h0010, 16'h1234, 1'b0);
    #1 chk("gate_off", mdr_out, 16'h0000);

    // byte reads of each half
    do_read("br11", 1'b1, 16'h0011, 16'h0012, 1'b0);
    do_read("br10", 1'b1, 16'h0010, 16'h0034, 1'b0);

    // ld_mar together with the request: access uses the new MAR
    access("same", 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b1, 0, lat, err, rd);
    chk("same_lat", lat, 5);
    chk("same_data", rd, 16'h1234);

    // byte write ignores the high byte; sign-extended byte read
    do_write("bw21", 1'b1, 16'h0021, 16'h005A, 1'b0);
    do_write("bw20", 1'b1, 16'h0020, 16'h7F80, 1'b0);
    do_read("br20", 1'b1, 16'h0020, 16'hFF80, 1'b0);
    do_read("wr20", 1'b0, 16'h0020, 16'h5A80, 1'b0);

    // unaligned word write: full latency, error, no array change
    do_write("bw13", 1'b1, 16'h0013, 16'h0011, 1'b0);
    do_write("bw14", 1'b1, 16'h0014, 16'h0022, 1'b0);
    access("uw13", 1'b1, 1'b0, 16'h0013, 16'hBEEF, 1'b1, 1'b0, 0, lat, err, rd);
    chk("uw13_lat", lat, 10);
    chk("uw13_err", err, 1'b1);
    do_read("br13", 1'b1, 16'h0013, 16'h0011, 1'b0);
    do_read("br14", 1'b1, 16'h0014, 16'h0022, 1'b0);
    // unaligned word read leaves MDR at the last read value
    do_read("ur15", 1'b0, 16'h0015, 16'h0022, 1'b1);

    // address taken modulo DEPTH
    do_write("ww1fe", 1'b0, 16'h01FE, 16'hA55A, 1'b0);
    do_read("wrfe", 1'b0, 16'h00FE, 16'hA55A, 1'b0);
    do_read("brff", 1'b1, 16'h00FF, 16'hFFA5, 1'b0);
    do_read("brfe", 1'b1, 16'h00FE, 16'h005A, 1'b0);

    // long hold in DONE with loads and rw/datasize churn while busy
    access("hold", 1'b1, 1'b0, 16'h0030, 16'h4321, 1'b1, 1'b0, 20, lat, err, rd);
    chk("hold_lat", lat, 10);
    chk("hold_mdr", rd, 16'h4321);
    do_read("wr30", 1'b0, 16'h0030, 16'h4321, 1'b0);

    // reset in the middle of a write
    do_write("ww40", 1'b0, 16'h0040, 16'h1357, 1'b0);
    @(negedge clk_50);
    bus = 16'hFFFF; ld_mdr = 1'b1;
    @(negedge clk_50);
    ld_mdr = 1'b0; bus = 16'h0040; ld_mar = 1'b1;
    @(negedge clk_50);
    ld_mar = 1'b0; mio_en = 1'b1; rw = 1'b1; datasize = 1'b0;
    @(posedge clk_50);
    repeat (4) @(posedge clk_50);
    #7 rst = 1'b1;
    #1 chk("midrst_r", r, 1'b0);
    gate_mdr = 1'b1;
    #1 chk("midrst_mdr", mdr_out, 16'h0000);
    gate_mdr = 1'b0;
    mio_en = 1'b0;
    @(negedge clk_50);
    rst = 1'b0;
    repeat (12) @(posedge clk_50);
    #1 chk("midrst_idle_r", r, 1'b0);
    do_read("wr40", 1'b0, 16'h0040, 16'h1357, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_unit.md
Name: lc3b_mem_unit

Overview:
- Parametrised successor to the LC-3b memory block: byte-addressable, little-endian storage behind MAR/MDR.
- Programmable read and write latency, and an R (ready) handshake that the microsequencer polls.
- Adds word/byte modes with sign-extended byte reads, an unaligned-access error flag, a gated MDR output, and reset.
- Sits on the LC-3b datapath bus beside the register file and ALU.

Parameters:
- ADDR_W, 16, MAR width in bits.
- DATA_W, 16, MDR/bus width; fixed at 2 bytes (word = 2 bytes).
- DEPTH, 256, array size in bytes; power of two; address index = mar mod DEPTH.
- RD_LAT, 5, cycles from accepted read request to R high; must be ≥ 1.
- WR_LAT, 10, cycles from accepted write request to R high; must be ≥ 1.

Ports:
- clk_50, in, 1, system clock; all state on rising edge.
- rst, in, 1, asynchronous active-high reset.
- bus, in, DATA_W, datapath bus value.
- ld_mar, in, 1, load MAR from bus.
- ld_mdr, in, 1, load MDR from bus.
- gate_mdr, in, 1, drive MDR onto mdr_out.
- mio_en, in, 1, memory request; held high until R seen.
- rw, in, 1, 1 = write, 0 = read.
- datasize, in, 1, 1 = byte, 0 = word.
- mdr_out, out, DATA_W, MDR when gate_mdr = 1, else 0; combinational.
- r, out, 1, access complete (ready).
- addr_err, out, 1, unaligned word access; valid while r = 1.

Behaviour:
- Reset (async):
  - State IDLE; mar, mdr and the counter go to 0; r = 0; addr_err = 0.
  - The array is NOT cleared.
  - Reset mid-access aborts the access; no partial write occurs.
- States:
  - IDLE → READ when mio_en = 1 and rw = 0.
  - IDLE → WRITE when mio_en = 1 and rw = 1.
  - READ/WRITE → DONE when the counter reaches 0.
  - DONE → IDLE when mio_en = 0.
- Counter:
  - Loaded with RD_LAT-1 or WR_LAT-1 on the IDLE→busy edge; decrements each cycle.
  - With mio_en sampled high at edge N, r rises at edge N+RD_LAT (read) or N+WR_LAT (write).
- In DONE, r holds high and the result/error holds stable until mio_en falls. r drops on the edge after mio_en = 0.
- rw and datasize are captured on request acceptance; changes while busy are ignored.
- ld_mar and ld_mdr act only in IDLE. In READ, WRITE and DONE they are ignored.
- Simultaneous ld_mar/ld_mdr with mio_en in IDLE: the registers load this edge, and the access starts using the new values next edge. The request is accepted at the same edge; the access itself uses post-load values.
- Address: a = mar mod DEPTH. Word accesses use a and a+1, with a+1 wrapping mod DEPTH.
- Word read (mar[0] = 0): on DONE entry, mdr = {mem[a+1], mem[a]}.
- Byte read: on DONE entry, mdr = sign-extended mem[a] (bit 7 replicated into [15:8]), for either parity of mar[0].
- Word write (mar[0] = 0): mem[a] = mdr[7:0], mem[a+1] = mdr[15:8], committed on DONE entry.
- Byte write: mem[a] = mdr[7:0]; mdr[15:8] ignored.
- Unaligned word access (datasize = 0, mar[0] = 1):
  - Full latency is still spent.
  - No array write; mdr unchanged.
  - addr_err = 1 together with r; it clears when DONE exits.
- Exactly one array commit per request; a long mio_en hold in DONE never re-commits.

Decomposition:
- Package lc3b_mem_pkg: state enum (IDLE, READ, WRITE, DONE), the sign-extend-byte function, and the RW_WRITE and SIZE_BYTE constants.
- One sub-module, lc3b_mem_array: a DEPTH×8 byte array with a registered write port (we, addr, wdata) and two combinational read ports (a and a+1).
- The FSM, counter, MAR and MDR stay in lc3b_mem_unit.

Test Plan:
- Word write/read:
  - Stimulus: ld_mar bus=0x0010; ld_mdr bus=0x1234; write word. Then read word at 0x0010.
  - Required: write r rises exactly 10 cycles after acceptance. Read r rises 5 cycles after acceptance with mdr_out = 0x1234 under gate_mdr. mem[0x10] = 0x34 and mem[0x11] = 0x12.
- Byte reads:
  - Stimulus: after the word write above, byte read at 0x0011, then byte read at 0x0010.
  - Required: mdr = 0x0012 and mdr = 0x0034. After a byte write of 0x80 to 0x0020, a byte read gives 0xFF80.
- Unaligned word:
  - Stimulus: word write at 0x0013 with mdr = 0xBEEF.
  - Required: r and addr_err rise together after 10 cycles; mem[0x13] and mem[0x14] unchanged; addr_err = 0 once r drops.
- Wrap:
  - Stimulus: DEPTH = 256, word write 0xA55A at mar = 0x01FE.
  - Required: mem[0xFE] = 0x5A, mem[0xFF] = 0xA5; a read at 0x00FE returns 0xA55A.
- Handshake:
  - Stimulus: hold mio_en high 20 cycles past r.
  - Required: r stays 1 with a single commit. ld_mdr pulses while busy do not change mdr. r falls one edge after mio_en drops.
- Reset mid-write:
  - Stimulus: assert rst 4 cycles into a word write of 0xFFFF to 0x0040, asynchronously between edges.
  - Required: r = 0 and mar/mdr = 0 immediately; mem[0x40..0x41] retain their prior values.
